// File: rtl/sudoku_pkg.sv
// Shared constants, state encoding and small lookup helpers for the Sudoku grid checker.
package sudoku_pkg;

    localparam int GRID_N     = 9;
    localparam int BOX_N      = 3;
    localparam int NUM_GROUPS = 27;
    localparam int CELL_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] KIND_ROW = 2'd0;
    localparam logic [1:0] KIND_COL = 2'd1;
    localparam logic [1:0] KIND_BOX = 2'd2;

    // Lookup tables replace a divider; inputs are only ever 0..8.
    function automatic logic [1:0] div3(input logic [3:0] x);
        logic [1:0] q;
        if (x < 4'd3)      q = 2'd0;
        else if (x < 4'd6) q = 2'd1;
        else               q = 2'd2;
        return q;
    endfunction

    function automatic logic [1:0] mod3(input logic [3:0] x);
        logic [1:0] r;
        case (x)
            4'd0, 4'd3, 4'd6: r = 2'd0;
            4'd1, 4'd4, 4'd7: r = 2'd1;
            default:          r = 2'd2;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] times3(input logic [1:0] q);
        return {1'b0, q, 1'b0} + {2'b00, q};
    endfunction

endpackage

// File: rtl/sudoku_group_addr.sv
// Maps (group g, cell c) onto a grid (row, col): groups 0..8 rows, 9..17 columns, 18..26 boxes.
module sudoku_group_addr
    import sudoku_pkg::*;
(
    input  logic [4:0] g,
    input  logic [3:0] c,
    output logic [3:0] row,
    output logic [3:0] col
);

    logic [1:0] kind;
    logic [3:0] col_idx;
    logic [3:0] box_idx;

    assign col_idx = 4'(g - 5'd9);
    assign box_idx = 4'(g - 5'd18);

    always_comb begin
        kind = KIND_ROW;
        if (g >= 5'd18)     kind = KIND_BOX;
        else if (g >= 5'd9) kind = KIND_COL;
    end

    always_comb begin
        row = 4'd0;
        col = 4'd0;
        case (kind)
            KIND_ROW: begin
                row = g[3:0];
                col = c;
            end
            KIND_COL: begin
                row = c;
                col = col_idx;
            end
            default: begin
                row = times3(div3(box_idx)) + {2'b00, div3(c)};
                col = times3(mod3(box_idx)) + {2'b00, mod3(c)};
            end
        endcase
    end

endmodule

// File: rtl/sudoku_check_ctrl.sv
// Walks a stored 9x9 grid by rows, columns and boxes, flagging duplicates/illegal values and empties.
// Optional build macro SUDOKU_EARLY_ABORT_EN stops the scan at the first detected error.
module sudoku_check_ctrl
    import sudoku_pkg::*;
#(
    parameter int CELL_W = CELL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [3:0]        rd_row,
    output logic [3:0]        rd_col,
    input  logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              incomplete
);

    state_e     state;
    logic [4:0] g;
    logic [3:0] c;
    logic [8:0] seen;
    logic       dly_en;
    logic [3:0] dly_c;

    logic [8:0] seen_base;
    logic [8:0] hit;
    logic       chk_err;
    logic       chk_zero;
    logic       abort;
    logic       last_issue;

    sudoku_group_addr u_addr (
        .g   (g),
        .c   (c),
        .row (rd_row),
        .col (rd_col)
    );

    // Read port: rd_en with (rd_row, rd_col) in cycle N returns rd_data in cycle N+1;
    // dly_en/dly_c mark which returning beat is valid and where it sits in its group.
    assign rd_en      = (state == SCAN);
    assign busy       = (state != IDLE);
    assign last_issue = (g == 5'(NUM_GROUPS - 1)) && (c == 4'(GRID_N - 1));

    always_comb begin
        hit = '0;
        for (int i = 0; i < GRID_N; i++) begin
            hit[i] = (rd_data == CELL_W'(i + 1));
        end
        seen_base = (dly_c == 4'd0) ? 9'd0 : seen;
        chk_zero  = dly_en && (rd_data == '0);
        chk_err   = dly_en && (rd_data != '0) && (~|hit || |(hit & seen_base));
    end

`ifdef SUDOKU_EARLY_ABORT_EN
    assign abort = (state == SCAN) && chk_err;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            g          <= 5'd0;
            c          <= 4'd0;
            seen       <= 9'd0;
            dly_en     <= 1'b0;
            dly_c      <= 4'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            incomplete <= 1'b0;
        end else begin
            done   <= 1'b0;
            dly_en <= rd_en && !abort;
            dly_c  <= c;

            if (dly_en) begin
                seen <= seen_base | hit;
                if (chk_err)  err        <= 1'b1;
                if (chk_zero) incomplete <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SCAN;
                        g          <= 5'd0;
                        c          <= 4'd0;
                        seen       <= 9'd0;
                        err        <= 1'b0;
                        incomplete <= 1'b0;
                    end
                end
                SCAN: begin
                    // Counters freeze on the final or aborting read so the address pins hold.
                    if (abort || last_issue) begin
                        state <= DRAIN;
                    end else if (c == 4'(GRID_N - 1)) begin
                        c <= 4'd0;
                        g <= g + 5'd1;
                    end else begin
                        c <= c + 4'd1;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_check_ctrl.sv
// Bench for sudoku_check_ctrl: grid memory model, address scoreboard, vector table and corner sequences.
module tb_sudoku_check_ctrl;

    localparam int CELL_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              rd_en;
    logic [3:0]        rd_row;
    logic [3:0]        rd_col;
    logic [CELL_W-1:0] rd_data = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic              incomplete;

    logic [3:0] grid [9][9];
    logic [7:0] exp_q [$];
    int n_vec  = 0;
    int n_fail = 0;

    sudoku_check_ctrl #(.CELL_W(CELL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .incomplete (incomplete)
    );

    always #5 clk = ~clk;

    // Synchronous-read grid storage: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            if (rd_row < 4'd9 && rd_col < 4'd9) rd_data <= grid[rd_row][rd_col];
            else                                rd_data <= 4'hF;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int ref_cell(input int r, input int c);
        return ((r * 3 + r / 3 + c) % 9) + 1;
    endfunction

    task automatic load_valid();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                grid[r][c] = 4'(ref_cell(r, c));
    endtask

    task automatic push_addrs();
        int row, col, b;
        exp_q.delete();
        for (int g = 0; g < 27; g++) begin
            for (int c = 0; c < 9; c++) begin
                if (g < 9) begin
                    row = g; col = c;
                end else if (g < 18) begin
                    row = c; col = g - 9;
                end else begin
                    b   = g - 18;
                    row = 3 * (b / 3) + c / 3;
                    col = 3 * (b % 3) + c % 3;
                end
                exp_q.push_back({4'(row), 4'(col)});
            end
        end
    endtask

    task automatic run_pass(input string tag, input bit exp_err, input bit exp_inc,
                            input bit check_timing, input bit poke_start);
        int n_rd = 0, first_rd = -1, last_rd = -1, done_cyc = -1, n_busy = 0;
        logic [7:0] e;
        push_addrs();
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
            @(negedge clk);
            start = poke_start && (k >= 50 && k < 70);
            if (rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = k;
                last_rd = k;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, " addr"}, {24'd0, rd_row, rd_col}, {24'd0, e});
                end
            end
            if (busy) n_busy++;
            if (done) done_cyc = k;
        end
        start = 1'b0;
        check({tag, " done_seen"}, int'(done_cyc > 0), 1);
        if (check_timing) begin
            check({tag, " rd_count"}, n_rd, 243);
            check({tag, " first_rd"}, first_rd, 1);
            check({tag, " last_rd"}, last_rd, 243);
            check({tag, " done_cycle"}, done_cyc, 245);
            check({tag, " busy_cycles"}, n_busy, 244);
            check({tag, " addr_left"}, exp_q.size(), 0);
        end
        check({tag, " err"}, int'(err), int'(exp_err));
        check({tag, " incomplete"}, int'(incomplete), int'(exp_inc));
        check({tag, " busy_at_done"}, int'(busy), 0);
        @(negedge clk);
        check({tag, " done_pulse"}, int'(done), 0);
        check({tag, " err_held"}, int'(err), int'(exp_err));
        check({tag, " inc_held"}, int'(incomplete), int'(exp_inc));
    endtask

    typedef struct {
        int         r0;
        int         c0;
        logic [3:0] v0;
        int         r1;
        int         c1;
        logic [3:0] v1;
        bit         zero_all;
        bit         exp_err;
        bit         exp_inc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit timing;
        int done_cnt, busy_cnt, done_cyc, last_rd, err_cyc;

        vecs[0] = '{-1, 0, 4'd0,  -1, 0, 4'd0,  1'b0, 1'b0, 1'b0}; // solved grid
        vecs[1] = '{ 4, 4, 4'd5,  -1, 0, 4'd0,  1'b0, 1'b1, 1'b0}; // row 4 duplicate
        vecs[2] = '{-1, 0, 4'd0,  -1, 0, 4'd0,  1'b1, 1'b0, 1'b1}; // all empty
        vecs[3] = '{ 8, 8, 4'd12, -1, 0, 4'd0,  1'b0, 1'b1, 1'b0}; // illegal 12
        vecs[4] = '{ 2, 7, 4'd0,  -1, 0, 4'd0,  1'b0, 1'b0, 1'b1}; // single empty
        vecs[5] = '{ 0, 0, 4'd0,   1, 1, 4'd15, 1'b0, 1'b1, 1'b1}; // empty plus illegal
        vecs[6] = '{ 5, 5, 4'd10, -1, 0, 4'd0,  1'b0, 1'b1, 1'b0}; // boundary value 10
        vecs[7] = '{ 3, 3, 4'd2,  -1, 0, 4'd0,  1'b0, 1'b1, 1'b0}; // row 3 duplicate

        load_valid();
        repeat (3) @(negedge clk);
        check("rst rd_en", int'(rd_en), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst err", int'(err), 0);
        check("rst incomplete", int'(incomplete), 0);
        check("rst addr", {24'd0, rd_row, rd_col}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            load_valid();
            if (vecs[i].zero_all)
                for (int r = 0; r < 9; r++)
                    for (int c = 0; c < 9; c++)
                        grid[r][c] = 4'd0;
            if (vecs[i].r0 >= 0) grid[vecs[i].r0][vecs[i].c0] = vecs[i].v0;
            if (vecs[i].r1 >= 0) grid[vecs[i].r1][vecs[i].c1] = vecs[i].v1;
`ifdef SUDOKU_EARLY_ABORT_EN
            timing = !vecs[i].exp_err;
`else
            timing = 1'b1;
`endif
            run_pass($sformatf("vec%0d", i), vecs[i].exp_err, vecs[i].exp_inc, timing, 1'b0);
        end

        // start pulses while busy must not disturb the pass
        load_valid();
        run_pass("busy_start", 1'b0, 1'b0, 1'b1, 1'b1);

        // reset at cycle 100 of a pass
        load_valid();
        grid[2][7] = 4'd0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrst pre busy", int'(busy), 1);
        check("midrst pre incomplete", int'(incomplete), 1);
        rst_n = 1'b0;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst rd_en", int'(rd_en), 0);
        check("midrst done", int'(done), 0);
        check("midrst err", int'(err), 0);
        check("midrst incomplete", int'(incomplete), 0);
        check("midrst addr", {24'd0, rd_row, rd_col}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("midrst no_done", done_cnt, 0);
        check("midrst no_busy", busy_cnt, 0);
        load_valid();
        run_pass("after_rst", 1'b0, 1'b0, 1'b1, 1'b0);

        // start held through done begins the next pass immediately
        load_valid();
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 400 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (done) done_cyc = k;
        end
        check("hold done_cycle", done_cyc, 245);
        @(negedge clk);
        check("hold restart rd_en", int'(rd_en), 1);
        check("hold restart busy", int'(busy), 1);
        check("hold restart addr", {24'd0, rd_row, rd_col}, 0);
        start = 1'b0;
        done_cyc = -1;
        for (int k = 2; k <= 400 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (done) done_cyc = k;
        end
        check("hold second done_cycle", done_cyc, 245);
        check("hold second err", int'(err), 0);

`ifdef SUDOKU_EARLY_ABORT_EN
        // duplicate in the first two reads aborts the pass
        load_valid();
        grid[0][0] = 4'd5;
        grid[0][1] = 4'd5;
        done_cyc = -1;
        last_rd  = -1;
        err_cyc  = -1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (rd_en) last_rd = k;
            if (err && err_cyc < 0) err_cyc = k;
            if (done && done_cyc < 0) done_cyc = k;
        end
        check("abort last_rd", last_rd, 3);
        check("abort err_cycle", err_cyc, 4);
        check("abort done_cycle", done_cyc, 5);
        check("abort err", int'(err), 1);
        check("abort incomplete", int'(incomplete), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
